rob_flush_sequencer: RTL and testbench

ROB_FLUSH_SEQUENCER -- requirements
Module: rob_flush_sequencer

---
 rtl/rob_flush_sequencer.sv | 116 +++++++++++
 tb/tb_rob_flush_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_flush_sequencer.sv
// Misprediction recovery: walks the ROB from tail-1 down to the entry after the
// mispredicted branch, undoing one rename per cycle. Optional macro ROB_FLUSH_STATS_EN adds recover_cnt.
module rob_flush_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       mispredict,
    input  logic [3:0] mis_rob_num,
    input  logic [3:0] rob_tail,
    input  logic [5:0] PR_old_rd,
    input  logic [5:0] PR_new_rd,
    input  logic [4:0] rd_rd,
    output logic       mis_ack,
    output logic [3:0] flush_idx,
    output logic       flush_valid,
    output logic [4:0] flush_rd,
    output logic [5:0] flush_PR_old,
    output logic [5:0] flush_PR_new,
    output logic       stall_dispatch,
    output logic       tail_set,
    output logic [3:0] tail_value,
    output logic       recover_done,
`ifdef ROB_FLUSH_STATS_EN
    output logic [7:0] recover_cnt,
`endif
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cursor_q, cursor_d;
    logic [3:0] b_q, b_d;
    logic [3:0] tail_m1;
    logic [3:0] b_plus1;
    logic       accept;

    // Handshake: mispredict is a request held by the branch unit; mis_ack is the
    // same-cycle grant, high only in IDLE, and the request is consumed on that clock edge.
    assign tail_m1   = rob_tail - 4'd1;
    assign b_plus1   = b_q + 4'd1;
    assign accept    = mispredict && (state_q == IDLE) && rst;
    assign mis_ack   = accept;
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cursor_q <= 4'd0;
            b_q      <= 4'd0;
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            b_q      <= b_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cursor_d       = cursor_q;
        b_d            = b_q;
        flush_valid    = 1'b0;
        flush_idx      = 4'd0;
        flush_rd       = 5'd0;
        flush_PR_old   = 6'd0;
        flush_PR_new   = 6'd0;
        tail_set       = 1'b0;
        tail_value     = 4'd0;
        recover_done   = 1'b0;
        stall_dispatch = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    b_d      = mis_rob_num;
                    cursor_d = tail_m1;
                    // Branch already youngest: nothing to undo, go straight to tail restore.
                    state_d  = (tail_m1 == mis_rob_num) ? DONE : WALK;
                end
            end
            WALK: begin
                flush_valid  = 1'b1;
                flush_idx    = cursor_q;
                flush_rd     = rd_rd;
                flush_PR_old = PR_old_rd;
                flush_PR_new = PR_new_rd;
                cursor_d     = cursor_q - 4'd1;
                if (cursor_q == b_plus1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                tail_set     = 1'b1;
                tail_value   = b_plus1;
                recover_done = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef ROB_FLUSH_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            recover_cnt <= 8'd0;
        end else if (state_q == DONE && recover_cnt != 8'hff) begin
            recover_cnt <= recover_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_flush_sequencer.sv
// Bench for rob_flush_sequencer: per-cycle compare against a queue model of the
// recovery sequence, plus literal checks on the observed flush order.
module tb_rob_flush_sequencer;

    logic       clk;
    logic       rst;
    logic       mispredict;
    logic [3:0] mis_rob_num;
    logic [3:0] rob_tail;
    logic [5:0] PR_old_rd;
    logic [5:0] PR_new_rd;
    logic [4:0] rd_rd;
    logic       mis_ack;
    logic [3:0] flush_idx;
    logic       flush_valid;
    logic [4:0] flush_rd;
    logic [5:0] flush_PR_old;
    logic [5:0] flush_PR_new;
    logic       stall_dispatch;
    logic       tail_set;
    logic [3:0] tail_value;
    logic       recover_done;
    logic [1:0] state_dbg;
`ifdef ROB_FLUSH_STATS_EN
    logic [7:0] recover_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model: entries <16 are walk indices, 16 marks the tail-restore cycle.
    logic [4:0] exp_q[$];
    logic [3:0] m_b = 4'd0;
    int         m_cnt = 0;

    int obs_idx[$];
    int obs_tail[$];
    int lit_q[$];

    logic [5:0] rob_old[16];
    logic [5:0] rob_new[16];
    logic [4:0] rob_rd[16];

    rob_flush_sequencer dut (
        .clk(clk), .rst(rst), .mispredict(mispredict), .mis_rob_num(mis_rob_num),
        .rob_tail(rob_tail), .PR_old_rd(PR_old_rd), .PR_new_rd(PR_new_rd), .rd_rd(rd_rd),
        .mis_ack(mis_ack), .flush_idx(flush_idx), .flush_valid(flush_valid),
        .flush_rd(flush_rd), .flush_PR_old(flush_PR_old), .flush_PR_new(flush_PR_new),
        .stall_dispatch(stall_dispatch), .tail_set(tail_set), .tail_value(tail_value),
        .recover_done(recover_done),
`ifdef ROB_FLUSH_STATS_EN
        .recover_cnt(recover_cnt),
`endif
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++) begin
            rob_old[i] = 6'(i + 16);
            rob_new[i] = 6'(i + 40);
            rob_rd[i]  = 5'(2 * i + 1);
        end
    end

    // ROB storage read combinationally at the DUT's flush index.
    assign PR_old_rd = rob_old[flush_idx];
    assign PR_new_rd = rob_new[flush_idx];
    assign rd_rd     = rob_rd[flush_idx];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic       e_walk, e_done, e_ack, e_busy;
        logic [3:0] e_idx, n4;
        e_walk = 1'b0;
        e_done = 1'b0;
        e_idx  = 4'd0;
        e_busy = rst && (exp_q.size() > 0);
        if (e_busy) begin
            if (exp_q[0] < 5'd16) begin
                e_walk = 1'b1;
                e_idx  = exp_q[0][3:0];
            end else begin
                e_done = 1'b1;
            end
        end
        e_ack = rst && mispredict && (exp_q.size() == 0);

        chk("mis_ack", int'(mis_ack), int'(e_ack));
        chk("stall_dispatch", int'(stall_dispatch), int'(e_busy));
        chk("flush_valid", int'(flush_valid), int'(e_walk));
        chk("flush_idx", int'(flush_idx), int'(e_idx));
        chk("flush_rd", int'(flush_rd), e_walk ? int'(rob_rd[e_idx]) : 0);
        chk("flush_PR_old", int'(flush_PR_old), e_walk ? int'(rob_old[e_idx]) : 0);
        chk("flush_PR_new", int'(flush_PR_new), e_walk ? int'(rob_new[e_idx]) : 0);
        chk("tail_set", int'(tail_set), int'(e_done));
        chk("recover_done", int'(recover_done), int'(e_done));
        chk("tail_value", int'(tail_value), e_done ? int'(4'(m_b + 4'd1)) : 0);
`ifdef ROB_FLUSH_STATS_EN
        chk("recover_cnt", int'(recover_cnt), rst ? m_cnt : 0);
`endif

        if (flush_valid) obs_idx.push_back(int'(flush_idx));
        if (tail_set) obs_tail.push_back(int'(tail_value));

        if (!rst) begin
            exp_q.delete();
            m_b   = 4'd0;
            m_cnt = 0;
        end else if (exp_q.size() > 0) begin
            if (e_done && m_cnt < 255) m_cnt++;
            void'(exp_q.pop_front());
        end else if (e_ack) begin
            m_b = mis_rob_num;
            n4  = rob_tail - mis_rob_num - 4'd1;
            for (int k = 0; k < int'(n4); k++) exp_q.push_back(5'(4'(rob_tail - 4'd1 - 4'(k))));
            exp_q.push_back(5'd16);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [3:0] mis, input logic [3:0] tail);
        mispredict  = 1'b1;
        mis_rob_num = mis;
        rob_tail    = tail;
        tick();
        mispredict  = 1'b0;
        // Tail and branch inputs move on; the walk must not notice.
        rob_tail    = tail + 4'd5;
        mis_rob_num = mis + 4'd3;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 40;
        while (exp_q.size() > 0 && budget > 0) begin
            tick();
            budget--;
        end
        chk("recovery_timeout", int'(exp_q.size() > 0), 0);
    endtask

    task automatic clear_obs();
        obs_idx.delete();
        obs_tail.delete();
    endtask

    task automatic check_obs(input string name, input int exp_tail);
        chk({name, "_len"}, obs_idx.size(), lit_q.size());
        for (int i = 0; i < lit_q.size(); i++)
            chk({name, "_idx"}, (i < obs_idx.size()) ? obs_idx[i] : -1, lit_q[i]);
        chk({name, "_tail_pulses"}, obs_tail.size(), 1);
        chk({name, "_tail_value"}, (obs_tail.size() > 0) ? obs_tail[0] : -1, exp_tail);
    endtask

    task automatic run_rec(input logic [3:0] mis, input logic [3:0] tail);
        clear_obs();
        accept(mis, tail);
        wait_idle();
        tick();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst         = 1'b0;
        mispredict  = 1'b1;
        mis_rob_num = 4'd3;
        rob_tail    = 4'd7;
        repeat (3) tick();
        mispredict = 1'b0;
        tick();
        rst = 1'b1;
        repeat (3) tick();

        run_rec(4'd3, 4'd7);
        lit_q = '{6, 5, 4};
        check_obs("basic", 4);

        run_rec(4'd14, 4'd2);
        lit_q = '{1, 0, 15};
        check_obs("wrap", 15);

        run_rec(4'd5, 4'd6);
        lit_q = '{};
        check_obs("empty", 6);

        // Request held through the walk must be ignored.
        clear_obs();
        accept(4'd3, 4'd7);
        mispredict  = 1'b1;
        mis_rob_num = 4'd9;
        rob_tail    = 4'd1;
        repeat (2) tick();
        mispredict = 1'b0;
        wait_idle();
        tick();
        lit_q = '{6, 5, 4};
        check_obs("busy_req", 4);

        run_rec(4'd10, 4'd10);
        lit_q = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 15, 14, 13, 12, 11};
        check_obs("full", 11);

        run_rec(4'd0, 4'd0);
        lit_q = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
        check_obs("full0", 1);

        run_rec(4'd15, 4'd0);
        lit_q = '{};
        check_obs("edge15", 0);

        // Reset during the second flush cycle.
        clear_obs();
        accept(4'd2, 4'd9);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("midrst_flushes", obs_idx.size(), 1);
        chk("midrst_first_idx", (obs_idx.size() > 0) ? obs_idx[0] : -1, 8);
        chk("midrst_tail_pulses", obs_tail.size(), 0);

        run_rec(4'd7, 4'd9);
        lit_q = '{8};
        check_obs("after_rst", 8);

`ifdef ROB_FLUSH_STATS_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) run_rec(4'd5, 4'd6);
        chk("stats_3", int'(recover_cnt), 3);
        for (int i = 0; i < 297; i++) run_rec(4'd5, 4'd6);
        chk("stats_sat", int'(recover_cnt), 255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
